// File: rtl/mips_cpu_hilo_unit.sv
// mips_cpu_hilo_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mips_cpu_hilo_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_p;
    logic [31:0] r_d, r_araw, r_hi, r_lo;
    logic        r_div, r_dz, r_neg_q, r_neg_r, r_done;
    logic        w_sgn, w_ge;
    logic [31:0] w_abs_a, w_abs_b, w_diff, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [32:0] w_sum, w_rs;
    logic [63:0] w_step, w_prod;
    assign w_sgn   = ~i_op[0];
    assign w_abs_a = (w_sgn & i_a[31]) ? -i_a : i_a;
    assign w_abs_b = (w_sgn & i_b[31]) ? -i_b : i_b;
    // r_p is {upper, lower}: product accumulator for multiply, {remainder, dividend/quotient} for divide
    assign w_sum   = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_d} : 33'd0);
    assign w_rs    = r_p[63:31];
    assign w_ge    = w_rs >= {1'b0, r_d};
    assign w_diff  = w_rs[31:0] - r_d;
    assign w_step  = r_div ? (w_ge ? {w_diff, r_p[30:0], 1'b1} : {w_rs[31:0], r_p[30:0], 1'b0})
                           : {w_sum, r_p[31:1]};
    assign w_prod  = r_neg_q ? -r_p : r_p;
    assign w_quo   = r_neg_q ? -r_p[31:0] : r_p[31:0];
    assign w_rem   = r_neg_r ? -r_p[63:32] : r_p[63:32];
    assign w_res_hi = r_div ? (r_dz ? r_araw : w_rem) : w_prod[63:32];
    assign w_res_lo = r_div ? (r_dz ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = (r_cnt == 6'd31) ? FIN : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_d     <= '0;
            r_araw  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (i_hi_we) r_hi <= i_wdata;
                    if (i_lo_we) r_lo <= i_wdata;
                    if (i_start) begin
                        r_div   <= i_op[1];
                        r_dz    <= i_op[1] & (i_b == 32'd0);
                        r_araw  <= i_a;
                        r_neg_q <= w_sgn & (i_a[31] ^ i_b[31]);
                        r_neg_r <= w_sgn & i_a[31];
                        r_cnt   <= '0;
                        r_d     <= i_op[1] ? w_abs_b : w_abs_a;
                        r_p     <= {32'd0, i_op[1] ? w_abs_a : w_abs_b};
                    end
                end
                RUN: begin
                    r_p   <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            endcase
        end
    end
    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: doc/mips_cpu_hilo_unit.md
# mips_cpu_hilo_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU. Executes MULT, MULTU, DIV and DIVU over multiple cycles, raising `busy` so the control path stalls. Its `hi`/`lo` outputs feed the MFHI/MFLO path into the register file `writedata`. It sits beside the ALU in the execute stage, directly upstream of the register file write port.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  launch the operation in `op`; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; the CPU must stall MFHI/MFLO/MTHI/MTLO/mul/div.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: `start`=1 latches |a| and |b| (signed ops take absolute values; unsigned ops use them raw). Also latches result-sign flags and clears the 6-bit iteration counter, then goes to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - After 32 steps, go to FIN.
- FIN: apply the sign fixup and write HI/LO, pulse `done`, return to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. For signed ops the product is negated if sign(a) XOR sign(b).
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient is negated if signs differ; remainder takes the sign of the dividend (truncating division).
  - 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0 (wraps; no exception).
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `a` as presented at start. Still runs the full latency.
- MTHI/MTLO: in IDLE, `hi_we`/`lo_we` writes `wdata` to HI/LO at the edge. They are ignored while `busy`=1.
- `start` while `busy`=1: ignored; no queuing.
- `start` together with `hi_we`/`lo_we` in IDLE: the write is applied and the operation launches. The operation's result later overwrites both HI and LO.
- Operands `a`, `b` and `op` need only be valid on the start edge.
- HI/LO hold their value indefinitely between operations.

## Timing
- Reset (`reset`=0, async): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. This applies immediately, with no clock required.
- Reset mid-operation aborts the operation. HI/LO become 0, not the partial result.
- Start accepted on edge N: `busy`=1 from after edge N.
- Steps occur on edges N+1 … N+32.
- FIN: HI/LO update on edge N+33.
  - `done`=1 and `busy`=0 for the cycle following edge N+33.
  - Total latency: 33 cycles from the start edge to the result being visible.
- `done` is high for exactly one cycle and never overlaps `busy`.
- Back-to-back: a `start` sampled on edge N+33 is not accepted, because the FSM is in FIN at that edge. The earliest re-launch is edge N+34.
- `hi`/`lo` are registered outputs. MFHI in the cycle after `done` reads the new value.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=5 → `done` after edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFF1. `busy` high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands → HI=0, LO=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678, after the full 33-cycle latency.
- MTHI 0xAAAA5555 in IDLE → `hi`=0xAAAA5555 next cycle. During a DIVU, assert `hi_we` and `start` → both ignored. The result is unaffected and no second operation runs.
- Start MULTU 7×9, assert `reset`=0 asynchronously mid-cycle at step 10 → `busy`, `done`, `hi` and `lo` go to 0 immediately. After release, MULTU 7×9 → LO=63, HI=0.
